// File: rtl/prf_arb_pkg.sv
// Shared types and width helpers for the PRF write-port arbiter.
package prf_arb_pkg;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  // Round-robin pointer width: $clog2(nreq), never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Zero-fill sweep counter width: $clog2(depth), never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prf_wb_arbiter_if.sv
// Writeback request bus and PRF write-port bus seen by the arbiter.
interface prf_wb_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NPORT = 2,
  parameter int unsigned INDEX = 4,
  parameter int unsigned WIDTH = 8
);
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ*INDEX-1:0]  req_addr_i;
  logic [NREQ*WIDTH-1:0]  req_data_i;
  logic [NREQ-1:0]        req_ready_o;
  logic                   reinit_i;
  logic [NPORT-1:0]       wr_we_o;
  logic [NPORT*INDEX-1:0] wr_addr_o;
  logic [NPORT*WIDTH-1:0] wr_data_o;
  logic                   init_busy_o;

  modport master (
    output req_valid_i, req_addr_i, req_data_i, reinit_i,
    input  req_ready_o, wr_we_o, wr_addr_o, wr_data_o, init_busy_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, reinit_i,
    output req_ready_o, wr_we_o, wr_addr_o, wr_data_o, init_busy_o
  );
endinterface

// File: rtl/rr_multi_pick.sv
// Combinational rotate-priority picker: up to NPORT one-hot grants in scan order from i_ptr,
// skipping requesters whose address collides with one already granted this cycle.
module rr_multi_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NPORT = 2,
  parameter int unsigned INDEX = 4,
  parameter int unsigned PW    = 2
) (
  input  logic [NREQ-1:0]            i_valid,
  input  logic [NREQ*INDEX-1:0]      i_addr,
  input  logic [PW-1:0]              i_ptr,
  output logic [NPORT-1:0][NREQ-1:0] o_gnt,
  output logic [NPORT-1:0]           o_port_vld,
  output logic [NREQ-1:0]            o_ready,
  output logic                       o_any,
  output logic [PW-1:0]              o_last
);
  localparam int unsigned SW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [NREQ-1:0][INDEX-1:0]  w_addr;
  logic [NPORT-1:0][INDEX-1:0] w_taken;
  logic [PW-1:0]               w_idx;
  logic                        w_conflict;
  int unsigned                 w_slot;

  assign w_addr = i_addr;

  always_comb begin
    o_gnt      = '0;
    o_port_vld = '0;
    o_ready    = '0;
    o_last     = '0;
    w_taken    = '0;
    w_idx      = '0;
    w_conflict = 1'b0;
    w_slot     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx      = PW'((32'(i_ptr) + i) % NREQ);
      w_conflict = 1'b0;
      for (int unsigned k = 0; k < NPORT; k++) begin
        if (k < w_slot && w_taken[SW'(k)] == w_addr[w_idx]) w_conflict = 1'b1;
      end
      // A conflicting requester waits without consuming a port slot.
      if (i_valid[w_idx] && w_slot < NPORT && !w_conflict) begin
        o_gnt[SW'(w_slot)][w_idx] = 1'b1;
        o_port_vld[SW'(w_slot)]   = 1'b1;
        w_taken[SW'(w_slot)]      = w_addr[w_idx];
        o_ready[w_idx]            = 1'b1;
        o_last                    = w_idx;
        w_slot                    = w_slot + 1;
      end
    end
  end

  assign o_any = |o_ready;

endmodule

// File: rtl/prf_wb_arbiter.sv
// PRF write-port scheduler: zero-fill sweep after reset/reinit, then round-robin sharing of
// NPORT registered write ports among NREQ writeback requesters.
module prf_wb_arbiter
  import prf_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NPORT = 2,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned INDEX = 4,
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  prf_wb_arbiter_if.slave bus
);
  localparam int unsigned    PW      = ptr_w(NREQ);
  localparam int unsigned    CW      = cnt_w(DEPTH);
  localparam int unsigned    SW      = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [CW-1:0]  LastCnt = CW'(DEPTH - 1);
  localparam logic [PW-1:0]  LastReq = PW'(NREQ - 1);

  state_e                      r_state, w_state_nxt;
  logic [CW-1:0]               r_cnt, w_cnt_nxt;
  logic [PW-1:0]               r_rr_ptr, w_rr_ptr_nxt;
  logic [NPORT-1:0]            r_we, w_we_nxt;
  logic [NPORT-1:0][INDEX-1:0] r_addr, w_addr_nxt;
  logic [NPORT-1:0][WIDTH-1:0] r_data, w_data_nxt;
  logic [NREQ-1:0][INDEX-1:0]  w_req_addr;
  logic [NREQ-1:0][WIDTH-1:0]  w_req_data;
  logic [NREQ-1:0]             w_pick_valid, w_ready;
  logic [NPORT-1:0][NREQ-1:0]  w_gnt;
  logic [NPORT-1:0]            w_port_vld;
  logic                        w_any, w_run;
  logic [PW-1:0]               w_last;

  assign w_req_addr   = bus.req_addr_i;
  assign w_req_data   = bus.req_data_i;
  assign w_run        = (r_state == StRun) && !bus.reinit_i;
  assign w_pick_valid = w_run ? bus.req_valid_i : '0;

  rr_multi_pick #(
    .NREQ  (NREQ),
    .NPORT (NPORT),
    .INDEX (INDEX),
    .PW    (PW)
  ) u_pick (
    .i_valid    (w_pick_valid),
    .i_addr     (bus.req_addr_i),
    .i_ptr      (r_rr_ptr),
    .o_gnt      (w_gnt),
    .o_port_vld (w_port_vld),
    .o_ready    (w_ready),
    .o_any      (w_any),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StInit;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rr_ptr_nxt = r_rr_ptr;
    unique case (r_state)
      StInit: begin
        w_cnt_nxt = (r_cnt == LastCnt) ? '0 : r_cnt + 1'b1;
        if (r_cnt == LastCnt) w_state_nxt = StRun;
      end
      StRun: begin
        if (bus.reinit_i) begin
          w_state_nxt  = StInit;
          w_cnt_nxt    = '0;
          w_rr_ptr_nxt = '0;
        end else if (w_any) begin
          w_rr_ptr_nxt = (w_last == LastReq) ? '0 : w_last + 1'b1;
        end
      end
    endcase
  end

  // Idle ports carry zero address/data so the bus is quiet when nothing is written.
  always_comb begin
    w_we_nxt   = '0;
    w_addr_nxt = '0;
    w_data_nxt = '0;
    if (r_state == StInit) begin
      w_we_nxt[0]   = 1'b1;
      w_addr_nxt[0] = INDEX'(r_cnt);
    end else begin
      for (int unsigned k = 0; k < NPORT; k++) begin
        w_we_nxt[SW'(k)] = w_port_vld[SW'(k)];
        for (int unsigned r = 0; r < NREQ; r++) begin
          w_addr_nxt[SW'(k)] = w_addr_nxt[SW'(k)]
                             | (w_req_addr[PW'(r)] & {INDEX{w_gnt[SW'(k)][PW'(r)]}});
          w_data_nxt[SW'(k)] = w_data_nxt[SW'(k)]
                             | (w_req_data[PW'(r)] & {WIDTH{w_gnt[SW'(k)][PW'(r)]}});
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we   <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we   <= w_we_nxt;
      r_addr <= w_addr_nxt;
      r_data <= w_data_nxt;
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.wr_we_o     = r_we;
  assign bus.wr_addr_o   = r_addr;
  assign bus.wr_data_o   = r_data;
  assign bus.init_busy_o = (r_state == StInit);

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Self-checking bench for prf_wb_arbiter: vector table plus sweep, reinit and async-reset sequences.
module tb_prf_wb_arbiter;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] addr;
    logic [31:0] data;
    logic        reinit;
    logic [3:0]  exp_ready;
    logic        exp_busy;
    logic [1:0]  exp_we;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    logic [1:0]  we;
    logic [7:0]  addr;
    logic [15:0] data;
  } cmd_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks;
  int   n_fail;
  cmd_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  prf_wb_arbiter_if #(.NREQ(4), .NPORT(2), .INDEX(4), .WIDTH(8)) bus ();

  prf_wb_arbiter #(
    .NREQ  (4),
    .NPORT (2),
    .DEPTH (16),
    .INDEX (4),
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic vec_t mk(input logic [3:0] v, input logic [15:0] a, input logic [31:0] d,
                              input logic ri, input logic [3:0] er, input logic eb,
                              input logic [1:0] ewe, input logic [7:0] ea, input logic [15:0] ed);
    vec_t t;
    t.valid = v; t.addr = a; t.data = d; t.reinit = ri;
    t.exp_ready = er; t.exp_busy = eb; t.exp_we = ewe; t.exp_addr = ea; t.exp_data = ed;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive at the falling edge, check combinational ready, then check the registered command.
  task automatic run_cycle(input vec_t v, input string nm);
    cmd_t c;
    cmd_t e;
    bus.req_valid_i = v.valid;
    bus.req_addr_i  = v.addr;
    bus.req_data_i  = v.data;
    bus.reinit_i    = v.reinit;
    #1;
    chk({nm, " ready"}, 64'(bus.req_ready_o), 64'(v.exp_ready));
    chk({nm, " busy"}, 64'(bus.init_busy_o), 64'(v.exp_busy));
    c.we = v.exp_we; c.addr = v.exp_addr; c.data = v.exp_data;
    exp_q.push_back(c);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({nm, " queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, " wr_we"}, 64'(bus.wr_we_o), 64'(e.we));
      chk({nm, " wr_addr"}, 64'(bus.wr_addr_o), 64'(e.addr));
      chk({nm, " wr_data"}, 64'(bus.wr_data_o), 64'(e.data));
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, " wr_we"}, 64'(bus.wr_we_o), 64'd0);
    chk({nm, " wr_addr"}, 64'(bus.wr_addr_o), 64'd0);
    chk({nm, " wr_data"}, 64'(bus.wr_data_o), 64'd0);
    chk({nm, " busy"}, 64'(bus.init_busy_o), 64'd1);
    chk({nm, " ready"}, 64'(bus.req_ready_o), 64'd0);
  endtask

  task automatic sweep(input logic [3:0] v, input logic [15:0] a, input logic [31:0] d,
                       input int reinit_at, input string nm);
    for (int c = 0; c < 16; c++) begin
      run_cycle(mk(v, a, d, 1'(c == reinit_at), 4'b0000, 1'b1, 2'b01, 8'(c), 16'h0000),
                $sformatf("%s%0d", nm, c));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected end before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    // Requesters: addr {a3,a2,a1,a0} and data {d3,d2,d1,d0}; expected {p1,p0} per port.
    tbl.push_back(mk(4'hF, 16'h3210, 32'h44332211, 0, 4'b0011, 0, 2'b11, 8'h10, 16'h2211));
    tbl.push_back(mk(4'hF, 16'h3210, 32'h44332211, 0, 4'b1100, 0, 2'b11, 8'h32, 16'h4433));
    tbl.push_back(mk(4'hF, 16'h3210, 32'h44332211, 0, 4'b0011, 0, 2'b11, 8'h10, 16'h2211));
    tbl.push_back(mk(4'hC, 16'h3210, 32'h44332211, 0, 4'b1100, 0, 2'b11, 8'h32, 16'h4433));
    tbl.push_back(mk(4'h7, 16'h0755, 32'hD3C2B1A0, 0, 4'b0101, 0, 2'b11, 8'h75, 16'hC2A0));
    tbl.push_back(mk(4'h2, 16'h0755, 32'hD3C2B1A0, 0, 4'b0010, 0, 2'b01, 8'h05, 16'h00B1));
    tbl.push_back(mk(4'h8, 16'h9755, 32'hA5C2B1A0, 0, 4'b1000, 0, 2'b01, 8'h09, 16'h00A5));
    tbl.push_back(mk(4'hF, 16'h3210, 32'h44332211, 0, 4'b0011, 0, 2'b11, 8'h10, 16'h2211));
    tbl.push_back(mk(4'hF, 16'h6686, 32'h44332211, 0, 4'b0110, 0, 2'b11, 8'h86, 16'h2233));

    reset           = 1'b0;
    bus.req_valid_i = 4'hF;
    bus.req_addr_i  = 16'h3210;
    bus.req_data_i  = 32'h44332211;
    bus.reinit_i    = 1'b0;
    #3;
    check_reset_state("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    sweep(4'hF, 16'h3210, 32'h44332211, -1, "sweep");
    for (int i = 0; i < tbl.size(); i++) run_cycle(tbl[i], $sformatf("vec%0d", i));

    // Reinit while req0 (addr 4, data 5A) waits; a reinit pulse mid-sweep is ignored.
    run_cycle(mk(4'h1, 16'h3214, 32'h4433225A, 1, 4'b0000, 0, 2'b00, 8'h00, 16'h0000), "reinit");
    sweep(4'h1, 16'h3214, 32'h4433225A, 5, "resweep");
    run_cycle(mk(4'h1, 16'h3214, 32'h4433225A, 0, 4'b0001, 0, 2'b01, 8'h04, 16'h005A), "post0");
    run_cycle(mk(4'h0, 16'h3214, 32'h4433225A, 0, 4'b0000, 0, 2'b00, 8'h00, 16'h0000), "post1");

    // Async reset with a live command on the ports.
    run_cycle(mk(4'hF, 16'h3210, 32'h44332211, 0, 4'b0110, 0, 2'b11, 8'h21, 16'h3322), "live");
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("async");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sweep(4'h0, 16'h3210, 32'h44332211, -1, "asweep");
    run_cycle(mk(4'hF, 16'h3210, 32'h44332211, 0, 4'b0011, 0, 2'b11, 8'h10, 16'h2211), "arun0");
    run_cycle(mk(4'h0, 16'h3210, 32'h44332211, 0, 4'b0000, 0, 2'b00, 8'h00, 16'h0000), "arun1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
